// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for rr_stream_mux: selection-mode encodings and the
// wrapped channel search helper used by the round-robin arbiter.
package rr_stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Channel visited 'step' positions after 'ptr', wrapping at nch.
    function automatic int rr_wrap_idx(input int ptr, input int step, input int nch);
        return (ptr + step) % nch;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arb.sv
// rr_arbiter: combinational round-robin grant. Searches ptr+1, ptr+2, ...
// (mod NCH) and grants the first requesting channel.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = SELW'(rr_wrap_idx(int'(ptr), k, NCH));
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel registered stream mux, round-robin or fixed select.
// Build option RR_STREAM_MUX_LOCK_EN adds in_last/out_last and packet locking.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int WIDTH = 16,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
`ifdef RR_STREAM_MUX_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic [WIDTH-1:0] ch_data [NCH];
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             rr_gnt_valid;
    logic [SELW-1:0]  rr_gnt_idx;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             load_en;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    assign load_en = !valid_q || out_ready;

`ifdef RR_STREAM_MUX_LOCK_EN
    logic            lock_q, lock_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            last_q, last_d;
`endif

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode == MODE_FIXED) begin
            if (int'(sel) < NCH) begin
                gnt_valid = in_valid[sel];
                gnt_idx   = sel;
            end
        end else begin
            gnt_valid = rr_gnt_valid;
            gnt_idx   = rr_gnt_idx;
        end
`ifdef RR_STREAM_MUX_LOCK_EN
        // An open packet overrides both selection modes until its last beat.
        if (lock_q) begin
            gnt_valid = in_valid[lock_ch_q];
            gnt_idx   = lock_ch_q;
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        if (load_en && gnt_valid && !rst) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
`ifdef RR_STREAM_MUX_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        last_d    = last_q;
`endif
        if (load_en) begin
            valid_d = gnt_valid;
            if (gnt_valid) begin
                data_d = ch_data[gnt_idx];
                ch_d   = gnt_idx;
                if (mode == MODE_RR) begin
                    ptr_d = gnt_idx;
                end
`ifdef RR_STREAM_MUX_LOCK_EN
                lock_d    = !in_last[gnt_idx];
                lock_ch_d = gnt_idx;
                last_d    = in_last[gnt_idx];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= SELW'(NCH - 1);
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
`ifdef RR_STREAM_MUX_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            last_q    <= 1'b0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
`ifdef RR_STREAM_MUX_LOCK_EN
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            last_q    <= last_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
`ifdef RR_STREAM_MUX_LOCK_EN
    assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_rr_stream_mux;

    localparam int NCH   = 16;
    localparam int WIDTH = 16;
    localparam int SELW  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic [NCH-1:0]       in_last;
    logic                 out_last;
`endif

    rr_stream_mux #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef RR_STREAM_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
        int last;
    } beat_t;

    beat_t          beats[$];
    int             errors = 0;
    int             checks = 0;
    logic [NCH-1:0] rdy_or;

    // Model state: contents of the output register and arbitration history.
    bit m_valid;
    int m_data, m_ch, m_ptr, m_last;
    bit m_lock;
    int m_lock_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_grant(output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (m_lock) begin
            gv = in_valid[m_lock_ch];
            g  = m_lock_ch;
        end else if (mode) begin
            if (int'(sel) < NCH && in_valid[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (!gv && in_valid[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        bit             gv;
        int             g;
        bit             load;
        logic [NCH-1:0] exp_rdy;
        int             lst;
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out_data", 32'(out_data), 0);
            check("rst_out_ch", 32'(out_ch), 0);
            check("rst_in_ready", 32'(in_ready), 0);
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NCH - 1;
            m_last = 0; m_lock = 0; m_lock_ch = 0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data", 32'(out_data), m_data);
            check("out_ch", 32'(out_ch), m_ch);
            lst = 0;
`ifdef RR_STREAM_MUX_LOCK_EN
            check("out_last", 32'(out_last), m_last);
            lst = int'(out_last);
`endif
            load = !m_valid || out_ready;
            model_grant(gv, g);
            exp_rdy = '0;
            if (load && gv) exp_rdy[g] = 1'b1;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            rdy_or |= in_ready;
            if (out_valid && out_ready)
                beats.push_back('{int'(out_ch), int'(out_data), lst});
            if (load) begin
                m_valid = gv;
                if (gv) begin
                    m_data = int'(in_data[g*WIDTH +: WIDTH]);
                    m_ch   = g;
                    if (!mode) m_ptr = g;
`ifdef RR_STREAM_MUX_LOCK_EN
                    m_last    = int'(in_last[g]);
                    m_lock    = !in_last[g];
                    m_lock_ch = g;
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int exp_sparse[4];
        exp_sparse = '{3, 12, 3, 12};
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        rdy_or    = '0;
`ifdef RR_STREAM_MUX_LOCK_EN
        in_last   = '1;
`endif
        cyc(3);
        rst = 1'b0;

        // Fairness: all channels valid, grants walk 0..15 then wrap.
        for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(16'hA000 + i);
        in_valid = '1;
        beats.delete();
        cyc(18);
        check("rr_beat_count", beats.size(), 17);
        for (int i = 0; i < beats.size(); i++) begin
            check("rr_ch", beats[i].ch, i % NCH);
            check("rr_data", beats[i].data, 32'hA000 + (i % NCH));
        end

        // Sparse round-robin after a fresh reset.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        in_valid = 16'h1008;
        beats.delete();
        cyc(5);
        check("sparse_count", beats.size(), 4);
        for (int i = 0; i < beats.size() && i < 4; i++) check("sparse_ch", beats[i].ch, exp_sparse[i]);
        in_valid = 16'h0008;
        beats.delete();
        cyc(4);
        check("sparse3_count", beats.size(), 4);
        for (int i = 0; i < beats.size(); i++) check("sparse3_ch", beats[i].ch, 3);

        // Fixed select on channel 5.
        mode = 1'b1;
        sel = 4'd5;
        in_valid = '1;
        beats.delete();
        rdy_or = '0;
        cyc(6);
        check("fix_rdy_or", 32'(rdy_or), 32'h0020);
        check("fix_count", beats.size(), 6);
        for (int i = 1; i < beats.size(); i++) check("fix_ch", beats[i].ch, 5);
        in_valid[5] = 1'b0;
        cyc(3);
        check("fix_drain_valid", 32'(out_valid), 0);

        // Backpressure on a beat from channel 7.
        sel = 4'd7;
        in_valid = '1;
        in_data[7*WIDTH +: WIDTH] = 16'h1234;
        cyc(1);
        check("bp_first_data", 32'(out_data), 32'h1234);
        check("bp_first_ch", 32'(out_ch), 7);
        out_ready = 1'b0;
        in_data[7*WIDTH +: WIDTH] = 16'h5678;
        repeat (4) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'h1234);
            check("bp_hold_ch", 32'(out_ch), 7);
            check("bp_hold_rdy", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_rdy", 32'(in_ready), 32'h0080);
        cyc(1);
        check("bp_next_data", 32'(out_data), 32'h5678);
        check("bp_next_valid", 32'(out_valid), 1);

        // Asynchronous reset while a beat is held.
        mode = 1'b0;
        in_valid = '1;
        cyc(3);
        check("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_ch", 32'(out_ch), 0);
        check("async_rst_rdy", 32'(in_ready), 0);
        cyc(1);
        rst = 1'b0;
        beats.delete();
        cyc(2);
        check("post_rst_count", beats.size(), 1);
        if (beats.size() > 0) check("post_rst_first_ch", beats[0].ch, 0);

`ifdef RR_STREAM_MUX_LOCK_EN
        // Packet lock: three beats from channel 2 before channel 9 is served.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        in_valid = 16'h0204;
        in_last = '1;
        in_last[2] = 1'b0;
        in_last[9] = 1'b0;
        beats.delete();
        cyc(2);
        in_last[2] = 1'b1;
        cyc(3);
        check("lock_count", beats.size(), 4);
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            check("lock_ch", beats[i].ch, (i < 3) ? 2 : 9);
            check("lock_last", beats[i].last, (i == 2) ? 1 : 0);
        end
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            in_valid = NCH'($urandom);
            if ($urandom_range(0, 1) == 0) in_valid &= NCH'($urandom);
            for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, NCH - 1));
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_STREAM_MUX_LOCK_EN
            in_last = NCH'($urandom) | NCH'($urandom);
`endif
            rst = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit stream multiplexer. It is the registered, handshaked successor to the team's combinational wide-select muxes.
- Selects one valid input per cycle and passes it to a single output register stage with a valid/ready handshake.
- Two selection modes:
  - round-robin arbitration;
  - fixed software-style select.
- Sits between multiple producer streams and one shared consumer (datapath/bus port).

Parameters:
- NCH, 16, number of input channels (2..64).
- WIDTH, 16, data width per channel.
- SELW, $clog2(NCH), channel index width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SELW  channel index used when mode = 1.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts beat.
- out_ch  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync-released use):
  - out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0.
  - RR pointer ptr = NCH-1, so channel 0 has first priority after reset.
  - Reset mid-transfer drops the held beat. No partial state survives.
- load_en = !out_valid | out_ready.
- Grant (combinational, from in_valid, mode, sel, ptr):
  - mode = 0: first i with in_valid[i] high, searching ptr+1, ptr+2, ... with wrap mod NCH.
  - mode = 1: grant sel iff in_valid[sel]. If sel >= NCH, there is no grant.
  - No valid request means no grant.
- in_ready[g] = load_en & grant_valid for the granted g only. All other in_ready bits are 0. in_ready never depends on in_valid of other channels in fixed mode.
- On the clock edge with load_en & grant_valid:
  - out_data <= data of g; out_ch <= g; out_valid <= 1.
  - ptr <= g (round-robin mode only; ptr holds in fixed mode).
- On load_en without a grant: out_valid <= 0. out_data and out_ch hold their last value.
- While out_valid & !out_ready: out_data and out_ch are stable, and all in_ready are 0.
- Timing:
  - Latency is 1 cycle from input handshake to out_valid.
  - Throughput is 1 beat/cycle with out_ready held high.
- Fairness: in round-robin mode with all NCH channels continuously valid and out_ready = 1, grants cycle 0, 1, ..., NCH-1, 0.
- mode/sel changes take effect on the next grant evaluation and never disturb a held beat.
- Simultaneous output drain and new load in the same cycle is legal (full rate).

Optional Feature:
- Macro: RR_STREAM_MUX_LOCK_EN.
- With the macro defined:
  - Adds ports in_last (input, NCH) and out_last (output, 1; registered with out_data; reset 0).
  - After a grant to channel g whose accepted beat has in_last[g] = 0, arbitration locks on g in both modes.
  - The lock releases after an accepted beat with in_last[g] = 1.
  - While locked, other channels see in_ready = 0, even if mode/sel change.
  - Reset clears the lock.
- Without the macro: no in_last/out_last ports, and arbitration is per beat.

Decomposition:
- Package rr_stream_mux_pkg holds:
  - constants MODE_RR = 1'b0 and MODE_FIXED = 1'b1;
  - a helper function computing the wrapped search index.
- One sub-module is natural: rr_arbiter (parameter NCH). Its ports are:
  - inputs req[NCH] and ptr[SELW];
  - outputs gnt_valid and gnt_idx[SELW].
- The top instantiates it for round-robin mode and muxes with fixed-select logic.

Test Plan:
- Reset: assert rst mid-stream with out_valid = 1 -> out_valid, out_data, out_ch immediately 0. After release, with all channels valid, the first grant goes to channel 0.
- Round-robin fairness: NCH = 16, all in_valid = 1, in_data[i] = 16'hA000 + i, out_ready = 1 -> out_ch sequence 0, 1, ..., 15, 0, each with matching data, one per cycle.
- Sparse round-robin: only channels 3 and 12 valid, ptr after reset -> grants 3, 12, 3, 12. When channel 12 drops, channel 3 is granted every cycle.
- Fixed mode: mode = 1, sel = 5, all valid -> only in_ready[5] is ever high and out_ch = 5 every beat. With sel = 5 and in_valid[5] = 0 -> out_valid falls to 0 after the drain.
- Backpressure: out_ready = 0 for 4 cycles after a beat from channel 7 (data 16'h1234) -> out_data stays 16'h1234, out_ch stays 7, all in_ready are 0. On out_ready = 1, the next beat loads in the same cycle.
- Lock (RR_STREAM_MUX_LOCK_EN): channel 2 sends 3 beats with last on the third while channel 9 is valid -> out_ch = 2, 2, 2, then 9, and out_last is high only on the third beat.
